// File: rtl/dcc_packet_scheduler.sv
// DCC packet scheduler: estop > round-robin slots > idle; one SELECT cycle, then OFFER until pkt_ready.
// Latency: packet offered one cycle after SELECT; offer held indefinitely while pkt_ready is low.
module dcc_packet_scheduler #(
  parameter int         NUM_SLOTS  = 4,
  parameter int         REPEAT     = 3,
  parameter logic [7:0] IDLE_ADDR  = 8'hFF,
  parameter logic [7:0] IDLE_CMD   = 8'h00,
  parameter logic [7:0] ESTOP_ADDR = 8'h00,
  parameter logic [7:0] ESTOP_CMD  = 8'h41
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [1:0]           wr_slot,
  input  logic [7:0]           wr_addr,
  input  logic [7:0]           wr_cmd,
  input  logic                 estop,
  input  logic                 pkt_ready,
  output logic                 pkt_valid,
  output logic [7:0]           pkt_addr,
  output logic [7:0]           pkt_cmd,
  output logic                 pkt_is_idle,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] slot_done
);

  localparam int CW = (REPEAT < 1) ? 1 : $clog2(REPEAT + 1);
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic { SELECT, OFFER } state_t;
  typedef enum logic [1:0] { SRC_IDLE, SRC_ESTOP, SRC_SLOT } src_t;

  state_t                state_q, state_d;
  src_t                  src_q, sel_src;
  logic [PW-1:0]         rr_q, sel_q, pick, wr_idx;
  logic [7:0]            slot_addr_q [NUM_SLOTS];
  logic [7:0]            slot_cmd_q  [NUM_SLOTS];
  logic [CW-1:0]         slot_cnt_q  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  slot_vld_q, done_q;
  logic [7:0]            pkt_addr_q, pkt_cmd_q, sel_addr, sel_cmd;
  logic                  found, xfer, wr_hit;

  assign xfer   = (state_q == OFFER) && pkt_ready;
  assign wr_hit = wr_en && (int'(wr_slot) < NUM_SLOTS);
  assign wr_idx = PW'(wr_slot);

  // Round-robin search starting at rr_q, wrapping to slot 0.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx  = (int'(rr_q) + i) % NUM_SLOTS;
      cand = PW'(idx);
      if (!found && slot_vld_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_src  = SRC_IDLE;
    sel_addr = IDLE_ADDR;
    sel_cmd  = IDLE_CMD;
    if (estop) begin
      sel_src  = SRC_ESTOP;
      sel_addr = ESTOP_ADDR;
      sel_cmd  = ESTOP_CMD;
    end else if (found) begin
      sel_src  = SRC_SLOT;
      sel_addr = slot_addr_q[pick];
      sel_cmd  = slot_cmd_q[pick];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SELECT:  state_d = OFFER;
      OFFER:   if (pkt_ready) state_d = SELECT;
      default: state_d = SELECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= SELECT;
      src_q      <= SRC_IDLE;
      rr_q       <= '0;
      sel_q      <= '0;
      slot_vld_q <= '0;
      done_q     <= '0;
      pkt_addr_q <= IDLE_ADDR;
      pkt_cmd_q  <= IDLE_CMD;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_addr_q[i] <= '0;
        slot_cmd_q[i]  <= '0;
        slot_cnt_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      if (state_q == SELECT) begin
        pkt_addr_q <= sel_addr;
        pkt_cmd_q  <= sel_cmd;
        src_q      <= sel_src;
        sel_q      <= pick;
      end
      if (xfer && src_q == SRC_SLOT) begin
        rr_q <= (sel_q == PW'(NUM_SLOTS - 1)) ? '0 : sel_q + 1'b1;
        // A same-cycle host write to this slot takes precedence over the decrement.
        if (!(wr_hit && wr_idx == sel_q)) begin
          slot_cnt_q[sel_q] <= slot_cnt_q[sel_q] - CW'(1);
          if (slot_cnt_q[sel_q] == CW'(1)) begin
            slot_vld_q[sel_q] <= 1'b0;
            done_q[sel_q]     <= 1'b1;
          end
        end
      end
      if (wr_hit) begin
        slot_addr_q[wr_idx] <= wr_addr;
        slot_cmd_q[wr_idx]  <= wr_cmd;
        slot_cnt_q[wr_idx]  <= CW'(REPEAT);
        slot_vld_q[wr_idx]  <= 1'b1;
      end
    end
  end

  assign pkt_valid   = (state_q == OFFER);
  assign pkt_addr    = pkt_addr_q;
  assign pkt_cmd     = pkt_cmd_q;
  assign pkt_is_idle = (state_q == OFFER) && (src_q == SRC_IDLE);
  assign slot_busy   = slot_vld_q;
  assign slot_done   = done_q;

endmodule

// File: tb/tb_dcc_packet_scheduler.sv
// Bench for dcc_packet_scheduler: directed scenarios plus random traffic against a transaction-level model.
module tb_dcc_packet_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0, wr_en = 1'b0, estop = 1'b0, pkt_ready = 1'b0;
  logic [1:0] wr_slot = 2'd0;
  logic [7:0] wr_addr = 8'h00, wr_cmd = 8'h00;
  logic       pkt_valid, pkt_is_idle;
  logic [7:0] pkt_addr, pkt_cmd;
  logic [3:0] slot_busy, slot_done;

  always #5 clk = ~clk;

  dcc_packet_scheduler dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_slot(wr_slot), .wr_addr(wr_addr),
    .wr_cmd(wr_cmd), .estop(estop), .pkt_ready(pkt_ready), .pkt_valid(pkt_valid),
    .pkt_addr(pkt_addr), .pkt_cmd(pkt_cmd), .pkt_is_idle(pkt_is_idle),
    .slot_busy(slot_busy), .slot_done(slot_done)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] a;
    logic [7:0] c;
    logic       i;
    logic [3:0] b;
    logic [3:0] d;
  } obs_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] c;
    logic       i;
  } ent_t;

  int   tests = 0, fails = 0;
  ent_t xlog[$];
  int   done_cnt[4];

  // Reference model: slot table, pointer and the packet currently being offered.
  logic [7:0] m_addr[4], m_cmd[4];
  bit         m_vld[4], m_done[4];
  int         m_cnt[4];
  int         m_rr, m_src;
  bit         m_offer;
  logic [7:0] m_pa, m_pc;

  task automatic model_edge();
    bit nd[4];
    int s;
    for (int k = 0; k < 4; k++) nd[k] = 1'b0;
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        m_vld[k] = 1'b0; m_cnt[k] = 0; m_addr[k] = 8'h00; m_cmd[k] = 8'h00;
      end
      m_rr = 0; m_src = -2; m_offer = 1'b0; m_pa = 8'hFF; m_pc = 8'h00;
    end else begin
      if (!m_offer) begin
        m_offer = 1'b1;
        if (estop) begin
          m_src = -1; m_pa = 8'h00; m_pc = 8'h41;
        end else begin
          m_src = -2;
          for (int k = 0; k < 4; k++) begin
            s = (m_rr + k) % 4;
            if (m_src == -2 && m_vld[s]) m_src = s;
          end
          if (m_src >= 0) begin m_pa = m_addr[m_src]; m_pc = m_cmd[m_src]; end
          else begin m_pa = 8'hFF; m_pc = 8'h00; end
        end
      end else if (pkt_ready) begin
        m_offer = 1'b0;
        if (m_src >= 0) begin
          m_rr = (m_src + 1) % 4;
          if (!(wr_en && int'(wr_slot) == m_src)) begin
            m_cnt[m_src] = m_cnt[m_src] - 1;
            if (m_cnt[m_src] == 0) begin m_vld[m_src] = 1'b0; nd[m_src] = 1'b1; end
          end
        end
      end
      if (wr_en) begin
        m_addr[wr_slot] = wr_addr; m_cmd[wr_slot] = wr_cmd;
        m_vld[wr_slot] = 1'b1; m_cnt[wr_slot] = 3;
      end
    end
    for (int k = 0; k < 4; k++) m_done[k] = nd[k];
  endtask

  function automatic obs_t m_obs();
    obs_t o;
    o.v = m_offer; o.a = m_pa; o.c = m_pc; o.i = m_offer && (m_src == -2);
    for (int k = 0; k < 4; k++) begin o.b[k] = m_vld[k]; o.d[k] = m_done[k]; end
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return obs_t'({pkt_valid, pkt_addr, pkt_cmd, pkt_is_idle, slot_busy, slot_done});
  endfunction

  function automatic int cnt_ent(input logic [7:0] a, input logic [7:0] c, input logic i);
    int n = 0;
    foreach (xlog[k]) if (xlog[k] == ent_t'({a, c, i})) n++;
    return n;
  endfunction

  function automatic int cnt_non_idle();
    int n = 0;
    foreach (xlog[k]) if (!xlog[k].i) n++;
    return n;
  endfunction

  task automatic cyc(input bit we, input int ws, input logic [7:0] wa, input logic [7:0] wc,
                     input bit es, input bit rd, input bit rn);
    @(negedge clk);
    wr_en = we; wr_slot = ws[1:0]; wr_addr = wa; wr_cmd = wc;
    estop = es; pkt_ready = rd; reset_n = rn;
    if (rn && pkt_valid && rd) xlog.push_back(ent_t'({pkt_addr, pkt_cmd, pkt_is_idle}));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 4; k++) if (slot_done[k]) done_cnt[k]++;
  endtask

  task automatic do_reset();
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 0);
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 0);
    xlog.delete();
    for (int k = 0; k < 4; k++) done_cnt[k] = 0;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      cyc(0, 0, 8'h00, 8'h00, 0, 1, 0);
      tests++;
      if (dut_obs() !== obs_t'({1'b0, 8'hFF, 8'h00, 1'b0, 4'h0, 4'h0})) begin
        fails++; $display("FAIL reset_values: got %h required %h", dut_obs(), obs_t'({1'b0, 8'hFF, 8'h00, 1'b0, 4'h0, 4'h0}));
      end
    end
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
    tests++;
    if (dut_obs() !== m_obs()) begin fails++; $display("FAIL reset_release: got %h required %h", dut_obs(), m_obs()); end
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
    tests++;
    if (pkt_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b required 1", pkt_valid); end
  endtask

  task automatic test_idle();
    xlog.delete();
    for (int n = 0; n < 10; n++) begin
      cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
      tests++;
      if (dut_obs() !== m_obs()) begin fails++; $display("FAIL idle_cycle %0d: got %h required %h", n, dut_obs(), m_obs()); end
    end
    tests++;
    if (xlog.size() != 5 || cnt_ent(8'hFF, 8'h00, 1'b1) != 5) begin
      fails++; $display("FAIL idle_stream: got %0d transfers (%0d idle) required 5", xlog.size(), cnt_ent(8'hFF, 8'h00, 1'b1));
    end
  endtask

  task automatic test_single_slot();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      cyc(n == 0, 1, 8'h03, 8'h74, 0, 1, 1);
      tests++;
      if (dut_obs() !== m_obs()) begin fails++; $display("FAIL single_cycle %0d: got %h required %h", n, dut_obs(), m_obs()); end
    end
    tests++;
    if (cnt_ent(8'h03, 8'h74, 1'b0) != 3 || cnt_non_idle() != 3) begin
      fails++; $display("FAIL single_count: got %0d slot transfers required 3", cnt_non_idle());
    end
    tests++;
    if (done_cnt[1] != 1 || slot_busy !== 4'h0) begin
      fails++; $display("FAIL single_done: got done=%0d busy=%b required done=1 busy=0000", done_cnt[1], slot_busy);
    end
    tests++;
    if (xlog[xlog.size()-1].i !== 1'b1) begin fails++; $display("FAIL single_tail_idle: got %b required 1", xlog[xlog.size()-1].i); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_ord[3];
    logic [7:0] got_ord[$];
    int bad = 0;
    exp_ord[0] = 8'h10; exp_ord[1] = 8'h12; exp_ord[2] = 8'h13;
    do_reset();
    cyc(1, 0, 8'h10, 8'h20, 0, 0, 1);
    cyc(1, 2, 8'h12, 8'h22, 0, 0, 1);
    cyc(1, 3, 8'h13, 8'h23, 0, 0, 1);
    for (int n = 0; n < 30; n++) begin
      cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
      tests++;
      if (dut_obs() !== m_obs()) begin fails++; $display("FAIL rr_cycle %0d: got %h required %h", n, dut_obs(), m_obs()); end
    end
    foreach (xlog[k]) if (!xlog[k].i) got_ord.push_back(xlog[k].a);
    foreach (got_ord[k]) if (k < 9 && got_ord[k] !== exp_ord[k % 3]) bad++;
    tests++;
    if (got_ord.size() != 9 || bad != 0) begin
      fails++; $display("FAIL rr_order: got %0d slot transfers, %0d out of order, required 9 in order 0,2,3", got_ord.size(), bad);
    end
  endtask

  task automatic test_estop();
    do_reset();
    cyc(1, 0, 8'h5A, 8'hA5, 0, 0, 1);
    for (int n = 0; n < 12; n++) begin
      cyc(0, 0, 8'h00, 8'h00, 1, 1, 1);
      tests++;
      if (dut_obs() !== m_obs()) begin fails++; $display("FAIL estop_cycle %0d: got %h required %h", n, dut_obs(), m_obs()); end
    end
    tests++;
    if (cnt_ent(8'h00, 8'h41, 1'b0) != 5 || cnt_non_idle() != 5 || slot_busy !== 4'b0001) begin
      fails++; $display("FAIL estop_only: got %0d estop of %0d non-idle busy=%b required 5 of 5 busy=0001",
                        cnt_ent(8'h00, 8'h41, 1'b0), cnt_non_idle(), slot_busy);
    end
    xlog.delete();
    for (int n = 0; n < 14; n++) begin
      cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
      tests++;
      if (dut_obs() !== m_obs()) begin fails++; $display("FAIL estop_resume %0d: got %h required %h", n, dut_obs(), m_obs()); end
    end
    tests++;
    if (cnt_ent(8'h5A, 8'hA5, 1'b0) != 3 || done_cnt[0] != 1) begin
      fails++; $display("FAIL estop_resume_count: got %0d transfers done=%0d required 3 done=1", cnt_ent(8'h5A, 8'hA5, 1'b0), done_cnt[0]);
    end
  endtask

  task automatic test_stall_rewrite();
    do_reset();
    cyc(1, 0, 8'h11, 8'h22, 0, 0, 1);
    cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
    for (int n = 0; n < 10; n++) begin
      cyc(n == 3, 0, 8'h05, 8'h60, 0, 0, 1);
      tests++;
      if ({pkt_valid, pkt_addr, pkt_cmd} !== {1'b1, 8'h11, 8'h22} || dut_obs() !== m_obs()) begin
        fails++; $display("FAIL stall_hold %0d: got %h required %h (pkt 11/22)", n, dut_obs(), m_obs());
      end
    end
    cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
    tests++;
    if ({pkt_valid, pkt_addr, pkt_cmd} !== {1'b1, 8'h05, 8'h60}) begin
      fails++; $display("FAIL stall_next: got %b/%h/%h required 1/05/60", pkt_valid, pkt_addr, pkt_cmd);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 1, 8'h77, 8'h11, 0, 0, 1);
    cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
    cyc(1, 1, 8'h66, 8'h99, 0, 1, 1);
    tests++;
    if (slot_busy !== 4'b0010 || slot_done !== 4'h0) begin
      fails++; $display("FAIL collide_write_wins: got busy=%b done=%b required 0010/0000", slot_busy, slot_done);
    end
    for (int n = 0; n < 12; n++) begin
      cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
      tests++;
      if (dut_obs() !== m_obs()) begin fails++; $display("FAIL collide_cycle %0d: got %h required %h", n, dut_obs(), m_obs()); end
    end
    tests++;
    if (cnt_ent(8'h77, 8'h11, 1'b0) != 1 || cnt_ent(8'h66, 8'h99, 1'b0) != 3 || done_cnt[1] != 1) begin
      fails++; $display("FAIL collide_counts: got old=%0d new=%0d done=%0d required 1/3/1",
                        cnt_ent(8'h77, 8'h11, 1'b0), cnt_ent(8'h66, 8'h99, 1'b0), done_cnt[1]);
    end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    cyc(1, 2, 8'h33, 8'h44, 0, 0, 1);
    cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
    cyc(0, 0, 8'h00, 8'h00, 0, 0, 1);
    tests++;
    if ({pkt_valid, pkt_addr} !== {1'b1, 8'h33}) begin fails++; $display("FAIL midrst_offer: got %b/%h required 1/33", pkt_valid, pkt_addr); end
    cyc(0, 0, 8'h00, 8'h00, 0, 1, 0);
    tests++;
    if (dut_obs() !== obs_t'({1'b0, 8'hFF, 8'h00, 1'b0, 4'h0, 4'h0})) begin
      fails++; $display("FAIL midrst_values: got %h required %h", dut_obs(), obs_t'({1'b0, 8'hFF, 8'h00, 1'b0, 4'h0, 4'h0}));
    end
    for (int n = 0; n < 6; n++) cyc(0, 0, 8'h00, 8'h00, 0, 1, 1);
    tests++;
    if (done_cnt[2] != 0 || cnt_ent(8'h33, 8'h44, 1'b0) != 0 || slot_busy !== 4'h0) begin
      fails++; $display("FAIL midrst_discard: got done=%0d xfers=%0d busy=%b required 0/0/0000",
                        done_cnt[2], cnt_ent(8'h33, 8'h44, 1'b0), slot_busy);
    end
  endtask

  task automatic test_random();
    bit es = 1'b0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 24) == 0) es = !es;
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          es, $urandom_range(0, 1) == 1, $urandom_range(0, 299) != 0);
      tests++;
      if (dut_obs() !== m_obs()) begin fails++; $display("FAIL random_cycle %0d: got %h required %h", n, dut_obs(), m_obs()); end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) done_cnt[k] = 0;
    test_reset();
    test_idle();
    test_single_slot();
    test_round_robin();
    test_estop();
    test_stall_rewrite();
    test_back_to_back();
    test_reset_mid_offer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
